// File: rtl/multicycle_core_if.sv
// Shared memory port of the multicycle core: request/ready handshake, one access at a time.
// The core holds req/we/addr/wdata steady until it samples ready; the memory may stall indefinitely.
interface multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB core; 3-5 cycles per instruction plus one per memory wait cycle.
// Memory backpressure via mem_ready stalls FETCH/MEM with all bus outputs held; no mem_ready-to-output path.
module multicycle_core #(
  parameter int          NREGS    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          LINK_REG = NREGS - 1
) (
  input  logic                clock,
  input  logic                reset,
  multicycle_core_if.master   mem,
  output logic [31:0]         pcQ,
  output logic [31:0]         instr,
  output logic                retire,
  output logic                illegal,
  output logic [2:0]          state
);
  localparam int IW = $clog2(NREGS);
  localparam logic [IW-1:0] LINK_IDX = IW'(LINK_REG);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BLEU = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ROLV = 6'b000100;
  localparam logic [5:0] FN_RORV = 6'b000110;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        retire_q, retire_d;
  logic        illegal_q, illegal_d;

  logic [31:0] rf_q [NREGS];
  logic          rf_we;
  logic [IW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;

  logic [5:0]    op, funct;
  logic [IW-1:0] rs_idx, rt_idx, rd_idx;
  logic [31:0]   simm, jtarget, rol_res, ror_res;
  logic          is_sw;

  assign op      = instr_q[31:26];
  assign funct   = instr_q[5:0];
  assign rs_idx  = instr_q[21 +: IW];
  assign rt_idx  = instr_q[16 +: IW];
  assign rd_idx  = instr_q[11 +: IW];
  assign simm    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign jtarget = {pc_q[31:28], instr_q[25:0], 2'b00};
  assign is_sw   = (op == OP_SW);
  // A zero rotate leaves the complementary shift at 32, which yields zero.
  assign rol_res = (b_q << a_q[4:0]) | (b_q >> (6'd32 - {1'b0, a_q[4:0]}));
  assign ror_res = (b_q >> a_q[4:0]) | (b_q << (6'd32 - {1'b0, a_q[4:0]}));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    unique case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          instr_d = mem.mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rs_idx];
        b_d     = rf_q[rt_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
        case (op)
          OP_R: begin
            case (funct)
              FN_ADD:  begin alu_d = a_q + b_q;    state_d = S_WB; retire_d = 1'b0; end
              FN_NOR:  begin alu_d = ~(a_q | b_q); state_d = S_WB; retire_d = 1'b0; end
              FN_ROLV: begin alu_d = rol_res;      state_d = S_WB; retire_d = 1'b0; end
              FN_RORV: begin alu_d = ror_res;      state_d = S_WB; retire_d = 1'b0; end
              FN_JR:   pc_d = a_q;
              default: illegal_d = 1'b1;
            endcase
          end
          OP_NORI: begin alu_d = ~(a_q | simm); state_d = S_WB; retire_d = 1'b0; end
          OP_LW, OP_SW: begin alu_d = a_q + simm; state_d = S_MEM; retire_d = 1'b0; end
          OP_BLEU: begin
            if (a_q <= b_q) pc_d = pc_q + (simm << 2);
          end
          OP_J: pc_d = jtarget;
          OP_JAL: begin
            pc_d     = jtarget;
            rf_we    = 1'b1;
            rf_waddr = LINK_IDX;
            rf_wdata = pc_q;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          if (is_sw) begin
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_R) ? rd_idx : rt_idx;
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
    end
  end

  // Register 0 is never written, so it reads as zero without a read-side mux.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != '0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign mem.mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem.mem_we    = (state_q == S_MEM) && is_sw;
  assign mem.mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem.mem_wdata = b_q;

  assign pcQ     = pc_q;
  assign instr   = instr_q;
  assign retire  = retire_q;
  assign illegal = illegal_q;
  assign state   = state_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed program bench for multicycle_core with a stallable word memory.
// Checks reset state, ALU results via stores, latencies, branches, jumps, illegal ops and reset abort.
module tb_multicycle_core;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_o, instr_o;
  logic        retire_o, illegal_o;
  logic [2:0]  state_o;

  always #5 clock = ~clock;

  multicycle_core_if bus ();

  multicycle_core #(.NREGS(8), .RESET_PC(RPC), .LINK_REG(7)) dut (
    .clock   (clock),
    .reset   (reset),
    .mem     (bus),
    .pcQ     (pc_o),
    .instr   (instr_o),
    .retire  (retire_o),
    .illegal (illegal_o),
    .state   (state_o)
  );

  logic [31:0] mem_arr [256];
  assign bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];

  int n_chk = 0;
  int n_pass = 0;
  int data_wait = 0;
  int stall_cnt = 0;
  int stab_err = 0;
  logic [31:0] ref_addr, ref_wdata;
  logic        ref_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    enc_r = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    enc_i = {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] addr);
    enc_j = {op, addr[27:2]};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem_arr[addr[9:2]] = w;
  endtask

  // Called at the falling edge of an instruction's first FETCH cycle; returns at its retire cycle.
  task automatic run_instr(input string tag, input int exp_lat, input logic exp_ill);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!retire_o && n < 40);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_ill"}, {31'b0, illegal_o}, {31'b0, exp_ill});
  endtask

  // Memory responder: stalls data accesses by data_wait cycles, fetches complete at once.
  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.mem_req && state_o == 3'd3 && stall_cnt < data_wait) begin
        if (stall_cnt == 0) begin
          ref_addr  = bus.mem_addr;
          ref_we    = bus.mem_we;
          ref_wdata = bus.mem_wdata;
        end else if (bus.mem_addr !== ref_addr || bus.mem_we !== ref_we ||
                     (ref_we && bus.mem_wdata !== ref_wdata)) begin
          stab_err++;
        end
        stall_cnt++;
        bus.mem_ready = 1'b0;
      end else begin
        if (bus.mem_req && state_o == 3'd3 && stall_cnt > 0 &&
            (bus.mem_addr !== ref_addr || bus.mem_we !== ref_we ||
             (ref_we && bus.mem_wdata !== ref_wdata))) stab_err++;
        bus.mem_ready = 1'b1;
        if (bus.mem_req && bus.mem_we) mem_arr[bus.mem_addr[9:2]] = bus.mem_wdata;
        stall_cnt = 0;
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    put(32'h100, enc_i(6'h0E, 0, 1, 16'hFFF0));       // nori r1,r0,0xFFF0
    put(32'h104, enc_r(1, 1, 2, 6'h20));              // add  r2,r1,r1
    put(32'h108, enc_r(2, 1, 3, 6'h04));              // rolv r3 = r1 rol r2
    put(32'h10C, enc_i(6'h2B, 0, 3, 16'h0200));       // sw r3,0x200
    put(32'h110, enc_i(6'h23, 0, 4, 16'h0200));       // lw r4,0x200
    put(32'h114, enc_i(6'h2B, 0, 4, 16'h020C));
    put(32'h118, enc_i(6'h2B, 0, 1, 16'h0204));
    put(32'h11C, enc_i(6'h2B, 0, 2, 16'h0208));
    put(32'h120, enc_i(6'h0E, 0, 5, 16'h0000));       // r5 = FFFFFFFF
    put(32'h124, enc_i(6'h0E, 0, 6, 16'hFFFE));       // r6 = 1
    put(32'h128, enc_i(6'h07, 5, 6, 16'h0010));       // bleu not taken
    put(32'h12C, enc_i(6'h07, 6, 5, 16'hFFFF));       // bleu taken to itself
    put(32'h140, enc_r(7, 0, 0, 6'h08));              // jr r7
    put(32'h130, enc_i(6'h2B, 0, 7, 16'h0210));
    put(32'h134, 32'hFC00_0000);                      // opcode 0x3F
    put(32'h138, enc_r(1, 1, 1, 6'h3F));              // bad funct, rd=r1
    put(32'h13C, enc_j(6'h02, 32'h150));
    put(32'h150, enc_i(6'h2B, 0, 1, 16'h0214));
    put(32'h154, enc_i(6'h0E, 0, 0, 16'h0000));       // write to r0 dropped
    put(32'h158, enc_i(6'h2B, 0, 0, 16'h0218));
    put(32'h15C, enc_r(2, 3, 5, 6'h06));              // rorv r5 = r3 ror r2
    put(32'h160, enc_r(1, 2, 6, 6'h27));              // nor r6,r1,r2
    put(32'h164, enc_i(6'h2B, 0, 5, 16'h021C));
    put(32'h168, enc_i(6'h2B, 0, 6, 16'h0220));
    put(32'h16C, enc_i(6'h23, 0, 1, 16'h0200));       // lw aborted by reset
    put(32'h218, 32'hDEAD_BEEF);

    repeat (3) @(negedge clock);
    chk("rst_state", {29'b0, state_o}, 32'd0);
    chk("rst_pc", pc_o, RPC);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_retire", {31'b0, retire_o}, 32'd0);
    chk("rst_illegal", {31'b0, illegal_o}, 32'd0);
    chk("rst_req", {31'b0, bus.mem_req}, 32'd1);
    chk("rst_addr", bus.mem_addr, RPC);
    reset = 1'b0;

    run_instr("nori", 4, 1'b0);
    run_instr("add", 4, 1'b0);
    run_instr("rolv", 4, 1'b0);
    data_wait = 3;
    run_instr("sw_stall", 7, 1'b0);
    chk("sw_addr", ref_addr, 32'h200);
    chk("sw_we", {31'b0, ref_we}, 32'd1);
    chk("sw_wdata", ref_wdata, 32'hC000_0003);
    run_instr("lw_stall", 8, 1'b0);
    chk("lw_addr", ref_addr, 32'h200);
    chk("lw_we", {31'b0, ref_we}, 32'd0);
    data_wait = 0;
    run_instr("sw_r4", 4, 1'b0);
    run_instr("sw_r1", 4, 1'b0);
    run_instr("sw_r2", 4, 1'b0);
    run_instr("nori_r5", 4, 1'b0);
    run_instr("nori_r6", 4, 1'b0);
    run_instr("bleu_nt", 3, 1'b0);
    chk("bleu_nt_pc", pc_o, 32'h12C);
    run_instr("bleu_t", 3, 1'b0);
    chk("bleu_t_pc", pc_o, 32'h12C);
    put(32'h12C, enc_j(6'h03, 32'h140));              // jal 0x140, before the refetch
    run_instr("jal", 3, 1'b0);
    chk("jal_pc", pc_o, 32'h140);
    run_instr("jr", 3, 1'b0);
    chk("jr_pc", pc_o, 32'h130);
    run_instr("sw_link", 4, 1'b0);
    run_instr("ill_op", 3, 1'b1);
    chk("ill_op_pc", pc_o, 32'h138);
    chk("ill_op_instr", instr_o, 32'hFC00_0000);
    run_instr("ill_fn", 3, 1'b1);
    chk("ill_fn_pc", pc_o, 32'h13C);
    run_instr("j", 3, 1'b0);
    chk("j_pc", pc_o, 32'h150);
    run_instr("sw_r1b", 4, 1'b0);
    run_instr("nori_r0", 4, 1'b0);
    run_instr("sw_r0", 4, 1'b0);
    run_instr("rorv", 4, 1'b0);
    run_instr("nor", 4, 1'b0);
    run_instr("sw_r5", 4, 1'b0);
    run_instr("sw_r6", 4, 1'b0);

    data_wait = 1;
    n = 0;
    while (state_o != 3'd3 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("abort_in_mem", {29'b0, state_o}, 32'd3);
    @(negedge clock);
    reset = 1'b1;                                     // coincides with mem_ready
    @(negedge clock);
    chk("abort_state", {29'b0, state_o}, 32'd0);
    chk("abort_pc", pc_o, RPC);
    chk("abort_retire", {31'b0, retire_o}, 32'd0);
    chk("abort_instr", instr_o, 32'h0);
    chk("abort_addr", bus.mem_addr, RPC);
    reset = 1'b0;
    data_wait = 0;
    run_instr("restart", 4, 1'b0);
    chk("restart_pc", pc_o, 32'h104);

    chk("m200_rolv", mem_arr[8'h80], 32'hC000_0003);
    chk("m204_r1", mem_arr[8'h81], 32'h0000_000F);
    chk("m208_r2", mem_arr[8'h82], 32'h0000_001E);
    chk("m20c_lw", mem_arr[8'h83], 32'hC000_0003);
    chk("m210_link", mem_arr[8'h84], 32'h0000_0130);
    chk("m214_r1_kept", mem_arr[8'h85], 32'h0000_000F);
    chk("m218_r0", mem_arr[8'h86], 32'h0000_0000);
    chk("m21c_rorv", mem_arr[8'h87], 32'h0000_000F);
    chk("m220_nor", mem_arr[8'h88], 32'hFFFF_FFE0);
    chk("bus_stable", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
